// File: rtl/fifo_wr_arb_if.sv
// Write-side bus between the requesters and the FIFO arbiter.
// master drives requests and FIFO status; slave is the arbiter.
interface fifo_wr_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic [IW-1:0]                 gnt_id;
    logic                          wr_en;
    logic [FIFO_WIDTH-1:0]         data_in;
    logic                          full;
    logic [15:0]                   beat_cnt;

    modport master (
        output req, req_data, full,
        input  gnt, gnt_id, wr_en, data_in, beat_cnt
    );

    modport slave (
        input  req, req_data, full,
        output gnt, gnt_id, wr_en, data_in, beat_cnt
    );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin FIFO write arbiter; grant, write and accept share one cycle.
// Define FIFO_ARB_BURST_EN to lock a grant for up to BURST_LEN beats.
module fifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int BURST_LEN  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    fifo_wr_arb_if.slave  bus
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      rr_nxt;
    logic [NUM_REQ-1:0] elig;
    logic               found;
    logic [IW-1:0]      win;
    logic               acc;
    logic [15:0]        beat_q;

    function automatic logic [IW-1:0] inc(input logic [IW-1:0] v);
        return (int'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
    endfunction

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && elig[(int'(rr_ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                win   = IW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign acc = found & ~bus.full & rst_n;

    always_comb begin
        bus.gnt     = '0;
        bus.gnt_id  = '0;
        bus.data_in = '0;
        if (acc) begin
            bus.gnt[win] = 1'b1;
            bus.gnt_id   = win;
            bus.data_in  = bus.req_data[int'(win)*FIFO_WIDTH +: FIFO_WIDTH];
        end
    end

    assign bus.wr_en    = acc;
    assign bus.beat_cnt = beat_q;

`ifdef FIFO_ARB_BURST_EN
    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] owner;
    logic [IW-1:0] owner_nxt;
    logic [4:0]    bcnt;
    logic [4:0]    bcnt_nxt;

    always_comb begin
        elig = bus.req;
        if (state == LOCK) begin
            elig        = '0;
            elig[owner] = bus.req[owner];
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        bcnt_nxt  = bcnt;
        rr_nxt    = rr_ptr;
        unique case (state)
            IDLE: begin
                if (acc) begin
                    state_nxt = LOCK;
                    owner_nxt = win;
                    bcnt_nxt  = 5'd1;
                end
            end
            LOCK: begin
                if (acc) begin
                    if (bcnt + 5'd1 == 5'(BURST_LEN)) begin
                        state_nxt = IDLE;
                        bcnt_nxt  = '0;
                        rr_nxt    = inc(owner);
                    end else begin
                        bcnt_nxt  = bcnt + 5'd1;
                    end
                end else if (!bus.req[owner] && !bus.full) begin
                    // owner gave up early: release and move past it
                    state_nxt = IDLE;
                    bcnt_nxt  = '0;
                    rr_nxt    = inc(owner);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= '0;
            bcnt  <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            bcnt  <= bcnt_nxt;
        end
    end
`else
    assign elig   = bus.req;
    assign rr_nxt = acc ? inc(win) : rr_ptr;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            beat_q <= '0;
        end else begin
            rr_ptr <= rr_nxt;
            if (acc) beat_q <= beat_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed table-driven bench for fifo_wr_arb (NUM_REQ=4, FIFO_WIDTH=16).
// Expected tables follow the build: single-beat or FIFO_ARB_BURST_EN.
module tb_fifo_wr_arb;
    logic clk;
    logic rst_n;
    int   errs;
    int   checks;

    fifo_wr_arb_if #(.NUM_REQ(4), .FIFO_WIDTH(16)) bus ();

    fifo_wr_arb #(
        .NUM_REQ(4),
        .FIFO_WIDTH(16),
        .BURST_LEN(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       full;
        logic [3:0] req;
        int         id;
        logic       wr;
        int         beat;
    } vec_t;

    vec_t tv[$];

    function automatic void add(logic r, logic f, logic [3:0] q,
                                int id, logic wr, int beat);
        vec_t v;
        v.rst_n = r;
        v.full  = f;
        v.req   = q;
        v.id    = id;
        v.wr    = wr;
        v.beat  = beat;
        tv.push_back(v);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        logic [3:0]  eg;
        logic [15:0] ed;
        errs   = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus.req  = '0;
        bus.full = 1'b0;
        for (int i = 0; i < 4; i++)
            bus.req_data[i*16 +: 16] = 16'hA000 + 16'(i);

`ifdef FIFO_ARB_BURST_EN
        add(0, 0, 4'b1111, 0, 0, 0);
        add(1, 0, 4'b0011, 0, 1, 0);
        add(1, 0, 4'b0011, 0, 1, 1);
        add(1, 0, 4'b0011, 0, 1, 2);
        add(1, 0, 4'b0011, 0, 1, 3);
        add(1, 0, 4'b0011, 1, 1, 4);
        add(1, 0, 4'b0011, 1, 1, 5);
        add(1, 0, 4'b0011, 1, 1, 6);
        add(1, 0, 4'b0011, 1, 1, 7);
        add(1, 0, 4'b0011, 0, 1, 8);
        add(1, 0, 4'b0000, 0, 0, 9);
        add(1, 0, 4'b0100, 2, 1, 9);
        add(1, 0, 4'b1100, 2, 1, 10);
        add(1, 0, 4'b1000, 0, 0, 11);
        add(1, 0, 4'b1100, 3, 1, 11);
        add(1, 1, 4'b1100, 0, 0, 12);
        add(1, 0, 4'b1100, 3, 1, 12);
        add(0, 0, 4'b1111, 0, 0, 13);
        add(1, 0, 4'b1110, 1, 1, 0);
        add(1, 0, 4'b0000, 0, 0, 1);
`else
        add(0, 0, 4'b1111, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            add(1, 0, 4'b1111, i % 4, 1, i);
        add(1, 0, 4'b0000, 0, 0, 8);
        add(1, 0, 4'b0101, 0, 1, 8);
        add(1, 1, 4'b0101, 0, 0, 9);
        add(1, 0, 4'b0101, 2, 1, 9);
        add(1, 0, 4'b0101, 0, 1, 10);
        add(1, 0, 4'b0100, 2, 1, 11);
        add(1, 0, 4'b1000, 3, 1, 12);
        add(1, 0, 4'b0010, 1, 1, 13);
        add(1, 1, 4'b1111, 0, 0, 14);
        add(1, 0, 4'b1011, 3, 1, 14);
        add(1, 0, 4'b1111, 0, 1, 15);
        add(1, 0, 4'b1111, 1, 1, 16);
        add(0, 0, 4'b1111, 0, 0, 17);
        add(1, 0, 4'b1110, 1, 1, 0);
        add(1, 0, 4'b0000, 0, 0, 1);
`endif

        repeat (2) @(negedge clk);

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            rst_n    = tv[i].rst_n;
            bus.full = tv[i].full;
            bus.req  = tv[i].req;
            #1;
            eg = tv[i].wr ? (4'b0001 << tv[i].id) : 4'b0000;
            ed = tv[i].wr ? 16'hA000 + 16'(tv[i].id) : 16'h0000;
            chk($sformatf("row%0d_gnt", i), 32'(bus.gnt), 32'(eg));
            chk($sformatf("row%0d_gnt_id", i), 32'(bus.gnt_id), 32'(tv[i].id));
            chk($sformatf("row%0d_wr_en", i), 32'(bus.wr_en), 32'(tv[i].wr));
            chk($sformatf("row%0d_data_in", i), 32'(bus.data_in), 32'(ed));
            chk($sformatf("row%0d_beat_cnt", i), 32'(bus.beat_cnt), 32'(tv[i].beat));
        end

        // beat counter wrap after 65536 accepts
        @(negedge clk);
        rst_n    = 1'b0;
        bus.full = 1'b0;
        bus.req  = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (65535) @(negedge clk);
        #1;
        chk("wrap_pre", 32'(bus.beat_cnt), 32'h0000_FFFF);
        chk("wrap_wr", 32'(bus.wr_en), 32'd1);
        @(negedge clk);
        #1;
        chk("wrap_post", 32'(bus.beat_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of write requesters (2..8).
REQ-002 The block SHALL have parameter FIFO_WIDTH, default 16, meaning the data word width.
REQ-003 The block SHALL have parameter BURST_LEN, default 4, meaning the maximum number of consecutive beats per locked grant (2..16).
REQ-004 The block SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  meaning a synchronous, active-low reset.
REQ-006 The block SHALL have port req  input  NUM_REQ  meaning per-requester write request.
REQ-007 The block SHALL have port req_data  input  NUM_REQ*FIFO_WIDTH  meaning per-requester word; slice i is bits [i*FIFO_WIDTH +: FIFO_WIDTH].
REQ-008 The block SHALL have port gnt  output  NUM_REQ  meaning one-hot grant; a word is accepted in any cycle with req[i] and gnt[i] both high.
REQ-009 The block SHALL have port gnt_id  output  $clog2(NUM_REQ)  meaning index of the current grant (0 when none).
REQ-010 The block SHALL have port wr_en  output  1  meaning FIFO write enable.
REQ-011 The block SHALL have port data_in  output  FIFO_WIDTH  meaning FIFO write data.
REQ-012 The block SHALL have port full  input  1  meaning FIFO full flag.
REQ-013 The block SHALL have port beat_cnt  output  16  meaning the total number of accepted words, wrapping at 16 bits.

Function
REQ-014 gnt SHALL be combinational: at most one bit high, never high when full=1, and never high for a requester with req low.
REQ-015 wr_en SHALL equal OR of gnt, and data_in SHALL equal the granted req_data slice; data_in SHALL be 0 when wr_en=0.
REQ-016 Latency: the grant, the FIFO write and the acceptance SHALL all occur in the same cycle, with no added pipeline stage.
REQ-017 The winner SHALL be the first requester with req high, searching from rr_ptr upward modulo NUM_REQ.
REQ-018 On each accept by requester i, rr_ptr SHALL become (i+1) mod NUM_REQ at the next edge.
REQ-019 While full=1, gnt SHALL be 0, and rr_ptr and all lock state SHALL hold.
REQ-020 Requesters SHALL hold req and data stable until accepted; the arbiter does not check this.
REQ-021 Dropping req before grant SHALL remove the requester from arbitration in that same cycle.
REQ-022 A requester with req held continuously SHALL be granted within NUM_REQ accepts (single-beat mode) or NUM_REQ*BURST_LEN accepts (burst mode).
REQ-023 beat_cnt SHALL increment by 1 per accepted word and wrap from 0xFFFF to 0x0000.

Reset
REQ-024 When rst_n=0 at a clock edge: rr_ptr=0, FSM=IDLE, burst counter=0, beat_cnt=0.
REQ-025 gnt and wr_en SHALL be forced to 0 combinationally while rst_n=0.
REQ-026 A reset in the middle of a burst SHALL abandon the lock, with no write issued in the reset cycle.

Configuration
REQ-027 With macro FIFO_ARB_BURST_EN defined, an FSM with states IDLE and LOCK SHALL be compiled in.
  - IDLE: an accept by requester i moves the FSM to LOCK with owner=i and burst counter=1.
  - LOCK: only the owner may be granted; each accept increments the burst counter.
  - LOCK -> IDLE when the counter reaches BURST_LEN, or when the owner's req is low while full=0.
  - rr_ptr SHALL update only on the LOCK->IDLE transition, to owner+1.
REQ-028 Without FIFO_ARB_BURST_EN, no FSM SHALL exist, and every accept SHALL advance rr_ptr as in REQ-018.

Verification
REQ-029 Scenario: reset, NUM_REQ=4, req=4'b1111 held, full=0 for 8 cycles, no burst -> gnt_id sequence 0,1,2,3,0,1,2,3 and beat_cnt=8.
REQ-030 Scenario: req=4'b0101, full pulses high in cycle 2 -> cycle 2 has gnt=0 and wr_en=0; cycle 3 grants the same requester that was pending in cycle 2.
REQ-031 Scenario: FIFO_ARB_BURST_EN, BURST_LEN=4, req=4'b0011 held -> gnt_id 0,0,0,0,1,1,1,1,0.
REQ-032 Scenario: FIFO_ARB_BURST_EN, owner 2 drops req after 2 beats -> FSM returns to IDLE and the next grant goes to requester 3 if it is requesting.
REQ-033 Scenario: rst_n=0 asserted mid-burst after beat 2 -> the next cycle has beat_cnt=0 and rr_ptr=0, and the first grant after reset goes to the lowest-index requester.
REQ-034 Scenario: beat_cnt preloaded by 65535 accepts, then one more accept -> beat_cnt=0.
